// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
// Covers memop encodings, FSM states, and load extraction / store merge.
package mem_pkg;

  typedef logic [2:0] memop_t;

  localparam memop_t MOP_B  = 3'b000;
  localparam memop_t MOP_H  = 3'b001;
  localparam memop_t MOP_W  = 3'b010;
  localparam memop_t MOP_BU = 3'b100;
  localparam memop_t MOP_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_RMW, ST_RESP} state_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] ofs,
                                               input memop_t op);
    logic [31:0] s;
    s = word >> {ofs, 3'b000};
    case (op)
      MOP_B:   return {{24{s[7]}}, s[7:0]};
      MOP_H:   return {{16{s[15]}}, s[15:0]};
      MOP_BU:  return {24'h0, s[7:0]};
      MOP_HU:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] ofs, input memop_t op);
    logic [31:0] mask;
    logic [31:0] data;
    case (op)
      MOP_B:   mask = 32'h0000_00ff;
      MOP_H:   mask = 32'h0000_ffff;
      default: mask = 32'hffff_ffff;
    endcase
    data = (wdata & mask) << {ofs, 3'b000};
    mask = mask << {ofs, 3'b000};
    return (word & ~mask) | data;
  endfunction

  // Unsigned loads have no store counterpart.
  function automatic logic op_supported(input logic we, input memop_t op);
    case (op)
      MOP_B, MOP_H, MOP_W: return 1'b1;
      MOP_BU, MOP_HU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input memop_t op, input logic [1:0] ofs);
    case (op)
      MOP_H, MOP_HU: return ofs[0];
      MOP_W:         return |ofs;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU data-bus request/response bundle for dmem_ctrl.
interface dmem_ctrl_if;
  import mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  memop_t      req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: read-first, registered read.
module dmem_ram #(
   parameter int    DEPTH_LOG2 = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready requests, region/op/alignment checks,
// sub-word stores as internal read-modify-write, one-cycle response pulses.
module dmem_ctrl import mem_pkg::*; #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [11:0] REGION     = 12'h001,
  parameter string       INIT_FILE  = ""
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);

  // state   | meaning
  // IDLE    | ready; accept, check, start RAM read or word write
  // RD      | RAM word registered; format load data into response
  // RMW     | RAM word registered; write merged sub-word store
  // RESP    | pulse response for stores and errors

  state_t                state, state_nxt;
  logic                  accept, err_hit;
  logic                  cap_we, cap_err;
  memop_t                cap_op;
  logic [1:0]            cap_ofs;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_wdata;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_wdata, ram_rdata;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic                  rsp_err_q, rsp_err_nxt;
  logic [31:0]           rsp_rdata_q, rsp_rdata_nxt;
  logic                  unused_addr;

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign accept  = bus.req_valid && bus.req_ready;
  assign err_hit = (bus.req_addr[31:20] != REGION) ||
                   !op_supported(bus.req_we, bus.req_op) ||
                   misaligned(bus.req_op, bus.req_addr[1:0]);
  // Index bits above the RAM depth alias within the region.
  assign unused_addr = ^bus.req_addr;

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt     = state;
    ram_we        = 1'b0;
    ram_addr      = cap_idx;
    ram_wdata     = lane_merge(ram_rdata, cap_wdata, cap_ofs, cap_op);
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = 32'h0;
    case (state)
      ST_IDLE: begin
        ram_addr  = bus.req_addr[DEPTH_LOG2+1:2];
        ram_wdata = bus.req_wdata;
        if (accept) begin
          if (err_hit) begin
            state_nxt = ST_RESP;
          end else if (!bus.req_we) begin
            state_nxt = ST_RD;
          end else if (bus.req_op == MOP_W) begin
            ram_we    = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_RMW;
          end
        end
      end
      ST_RD: begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = lane_extract(ram_rdata, cap_ofs, cap_op);
        state_nxt     = ST_IDLE;
      end
      ST_RMW: begin
        ram_we    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = cap_err;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A reset landing on the RMW write edge must leave memory untouched.
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      cap_we      <= 1'b0;
      cap_err     <= 1'b0;
      cap_op      <= MOP_W;
      cap_ofs     <= 2'b00;
      cap_idx     <= '0;
      cap_wdata   <= 32'h0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_err   <= err_hit;
        cap_op    <= bus.req_op;
        cap_ofs   <= bus.req_addr[1:0];
        cap_idx   <= bus.req_addr[DEPTH_LOG2+1:2];
        cap_wdata <= bus.req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.DEPTH_LOG2(12), .REGION(12'h001), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request starting at a negedge; lat counts posedges from the
  // accepting edge (inclusive) up to the edge that raises rsp_valid.
  task automatic do_req(input logic we, input memop_t op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge clk);
    check("rsp_pulse_len", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = MOP_W;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    rst = 1'b0;

    do_req(1'b1, MOP_W, 32'h0010_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("sw_err", {31'h0, er}, 32'h0);
    check("sw_rdata", rd, 32'h0);
    check("sw_lat", lat, 2);
    do_req(1'b0, MOP_W, 32'h0010_0010, 32'h0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", {31'h0, er}, 32'h0);
    check("lw_lat", lat, 2);

    do_req(1'b1, MOP_B, 32'h0010_0011, 32'h0000_007F, rd, er, lat);
    check("sb_lat", lat, 3);
    check("sb_err", {31'h0, er}, 32'h0);
    do_req(1'b0, MOP_W, 32'h0010_0010, 32'h0, rd, er, lat);
    check("sb_lw", rd, 32'hDEAD_7FEF);
    do_req(1'b0, MOP_B, 32'h0010_0011, 32'h0, rd, er, lat);
    check("lb", rd, 32'h0000_007F);
    do_req(1'b0, MOP_BU, 32'h0010_0013, 32'h0, rd, er, lat);
    check("lbu", rd, 32'h0000_00DE);
    do_req(1'b0, MOP_B, 32'h0010_0013, 32'h0, rd, er, lat);
    check("lb_neg", rd, 32'hFFFF_FFDE);

    do_req(1'b1, MOP_H, 32'h0010_0012, 32'hFFFF_8001, rd, er, lat);
    check("sh_lat", lat, 3);
    do_req(1'b0, MOP_H, 32'h0010_0012, 32'h0, rd, er, lat);
    check("lh", rd, 32'hFFFF_8001);
    do_req(1'b0, MOP_HU, 32'h0010_0012, 32'h0, rd, er, lat);
    check("lhu", rd, 32'h0000_8001);
    do_req(1'b0, MOP_W, 32'h0010_0010, 32'h0, rd, er, lat);
    check("sh_lw", rd, 32'h8001_7FEF);

    do_req(1'b0, MOP_W, 32'h0010_0002, 32'h0, rd, er, lat);
    check("err_lw_mis", {31'h0, er}, 32'h1);
    check("err_lw_mis_rdata", rd, 32'h0);
    check("err_lat", lat, 2);
    do_req(1'b0, MOP_H, 32'h0010_0001, 32'h0, rd, er, lat);
    check("err_lh_mis", {31'h0, er}, 32'h1);
    do_req(1'b1, MOP_W, 32'h0020_0010, 32'hFFFF_FFFF, rd, er, lat);
    check("err_region", {31'h0, er}, 32'h1);
    check("err_region_rdata", rd, 32'h0);
    do_req(1'b1, MOP_BU, 32'h0010_0010, 32'h1234_5678, rd, er, lat);
    check("err_st_op", {31'h0, er}, 32'h1);
    do_req(1'b0, MOP_W, 32'h0010_0010, 32'h0, rd, er, lat);
    check("err_readback", rd, 32'h8001_7FEF);
    check("err_readback_err", {31'h0, er}, 32'h0);

    for (int i = 0; i < 4; i++)
      do_req(1'b1, MOP_W, 32'h0010_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i), rd, er, lat);

    // req_valid stays high across four loads; one accept every two cycles.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_op    = MOP_W;
    bus.req_addr  = 32'h0010_0040;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.req_addr = 32'h0010_0000;
      check("b2b_ready_rd", {31'h0, bus.req_ready}, 32'h0);
      check("b2b_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("b2b_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check("b2b_rdata", bus.rsp_rdata, 32'hA000_0000 + 32'(i));
      check("b2b_ready_idle", {31'h0, bus.req_ready}, 32'h1);
      if (i < 3) bus.req_addr = 32'h0010_0044 + 32'(4 * i);
      else bus.req_valid = 1'b0;
    end

    do_req(1'b1, MOP_W, 32'h0010_0020, 32'h1122_3344, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_op    = MOP_B;
    bus.req_addr  = 32'h0010_0020;
    bus.req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_ready", {31'h0, bus.req_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rmw_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rmw_rst_no_rsp", {31'h0, seen}, 32'h0);
    do_req(1'b0, MOP_W, 32'h0010_0020, 32'h0, rd, er, lat);
    check("rmw_rst_readback", rd, 32'h1122_3344);

    do_req(1'b1, MOP_W, 32'h0010_4000, 32'h0000_0001, rd, er, lat);
    check("wrap_err", {31'h0, er}, 32'h0);
    do_req(1'b0, MOP_W, 32'h0010_0000, 32'h0, rd, er, lat);
    check("wrap_alias", rd, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
